// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - fetch/decode sequencer for a 1-bit logic unit over a synchronous ROM
// Optional return stack compiled in with FD_CALL_STACK_EN.
module fetch_decode #(
  parameter int SIZE_LOG    = 12,
  parameter int IO_W        = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIZE_LOG-1:0] pc_addr,
  input  logic [SIZE_LOG+3:0] rom_data,
  input  logic                rr,
  output logic                pc_write,
  output logic [SIZE_LOG-1:0] pc_target,
  output logic                instr_valid,
  output logic [3:0]          opcode,
  output logic [IO_W-1:0]     io_addr,
  output logic                jmp_flag,
  output logic                rtn_flag,
  output logic                flg0,
  output logic                flgf,
  output logic                stk_ovf,
  output logic                stk_unf
);

  localparam logic [3:0] OP_NOP0 = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  typedef enum logic [1:0] {RST_LOAD, FILL, RUN} state_t;

  state_t              state, state_nxt;
  logic                squash, squash_nxt;
  logic [SIZE_LOG-1:0] instr_addr;
  logic [SIZE_LOG-1:0] operand;

  assign opcode  = rom_data[SIZE_LOG+3:SIZE_LOG];
  assign operand = rom_data[SIZE_LOG-1:0];
  assign io_addr = rom_data[IO_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RST_LOAD;
      squash     <= 1'b0;
      instr_addr <= '0;
    end else begin
      state      <= state_nxt;
      squash     <= squash_nxt;
      instr_addr <= pc_addr;
    end
  end

`ifdef FD_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SIZE_LOG-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp, sp_m1;
  logic                push, pop, stk_full, stk_empty;
  logic [SIZE_LOG-1:0] stack_top;
  logic                ovf_q, unf_q;

  assign sp_m1     = sp - 1'b1;
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign stack_top = stack[sp_m1[IDX_W-1:0]];
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push) begin
        if (stk_full) ovf_q <= 1'b1;
        else          sp    <= sp + 1'b1;
      end
      if (pop) begin
        if (stk_empty) unf_q <= 1'b1;
        else           sp    <= sp_m1;
      end
    end
  end

  // Entries above the pointer are dead, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push && !stk_full) stack[sp[IDX_W-1:0]] <= instr_addr + 1'b1;
  end
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic unused_instr_addr;

  assign unused_instr_addr = ^instr_addr;
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    squash_nxt  = 1'b0;
    pc_write    = 1'b0;
    pc_target   = operand;
    instr_valid = 1'b0;
    jmp_flag    = 1'b0;
    rtn_flag    = 1'b0;
    flg0        = 1'b0;
    flgf        = 1'b0;
`ifdef FD_CALL_STACK_EN
    push        = 1'b0;
    pop         = 1'b0;
`endif
    case (state)
      RST_LOAD: begin
        pc_write  = 1'b1;
        pc_target = '0;
        state_nxt = FILL;
      end
      FILL: state_nxt = RUN;
      RUN: begin
        instr_valid = !squash;
        if (!squash) begin
          case (opcode)
            OP_NOP0: flg0 = 1'b1;
            OP_NOPF: flgf = 1'b1;
            OP_JMP: begin
              jmp_flag   = 1'b1;
              pc_write   = 1'b1;
              pc_target  = operand;
              squash_nxt = 1'b1;
`ifdef FD_CALL_STACK_EN
              push       = 1'b1;
`endif
            end
            OP_RTN: begin
              rtn_flag   = 1'b1;
              squash_nxt = 1'b1;
`ifdef FD_CALL_STACK_EN
              pop        = 1'b1;
              if (!stk_empty) begin
                pc_write  = 1'b1;
                pc_target = stack_top;
              end
`endif
            end
            OP_SKZ:  squash_nxt = !rr;
            default: ;
          endcase
        end
      end
      default: state_nxt = RST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed scoreboard bench for fetch_decode with a PC + synchronous ROM model
module tb_fetch_decode;

  localparam int SL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rr = 1'b1;
  logic [SL-1:0] pc_addr = '0;
  logic [SL+3:0] rom_data = '0;
  logic          pc_write, instr_valid, jmp_flag, rtn_flag, flg0, flgf, stk_ovf, stk_unf;
  logic [SL-1:0] pc_target;
  logic [3:0]    opcode;
  logic [3:0]    io_addr;

  fetch_decode #(.SIZE_LOG(SL), .IO_W(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .rom_data(rom_data), .rr(rr),
    .pc_write(pc_write), .pc_target(pc_target), .instr_valid(instr_valid),
    .opcode(opcode), .io_addr(io_addr), .jmp_flag(jmp_flag), .rtn_flag(rtn_flag),
    .flg0(flg0), .flgf(flgf), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:4095];

  always @(posedge clk) begin
    pc_addr  <= pc_write ? pc_target : pc_addr + 1'b1;
    rom_data <= rom[pc_addr];
  end

  typedef struct {
    string       tag;
    logic [27:0] val;
    logic [27:0] care;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [27:0] obs;

  assign obs = {instr_valid, opcode, io_addr, pc_write, pc_target,
                jmp_flag, rtn_flag, flg0, flgf, stk_ovf, stk_unf};

  // fl = {jmp, rtn, flg0, flgf}; stk = {ovf, unf}; opc=0 masks opcode/io_addr
  task automatic e(input string tag, input int v, input int op, input int io, input int pw,
                   input int tgt, input int fl, input int stk, input int opc);
    exp_t x;
    x.tag  = tag;
    x.val  = {1'(v), 4'(op), 4'(io), 1'(pw), 12'(tgt), 4'(fl), 2'(stk)};
    x.care = {1'b1, {8{1'(opc)}}, 1'b1, {12{1'(pw)}}, 6'h3F};
    sb.push_back(x);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t x;
      @(negedge clk);
      x = sb.pop_front();
      vectors++;
      assert ((obs & x.care) === (x.val & x.care)) else begin
        miscompares++;
        $error("FAIL %s: observed=%07h expected=%07h care=%07h", x.tag, obs, x.val, x.care);
      end
    end
  endtask

  task automatic do_reset(input logic r);
    rr    = r;
    rst_n = 1'b0;
    e("rst_load", 0, 0, 0, 1, 0, 0, 0, 0);
    drain();
    rst_n = 1'b1;
    e("fill", 0, 0, 0, 0, 0, 0, 0, 0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'h2000;
    rom[12'h000] = 16'h1003; rom[12'h001] = 16'h0000; rom[12'h002] = 16'hE000;
    rom[12'h003] = 16'hC080; rom[12'h004] = 16'hF000; rom[12'h005] = 16'hC040;
    rom[12'h006] = 16'h2006;
    rom[12'h040] = 16'h3005; rom[12'h041] = 16'h800A; rom[12'h042] = 16'hD000;
    rom[12'h043] = 16'h5000; rom[12'h044] = 16'h6009;
    rom[12'h080] = 16'h900B; rom[12'h081] = 16'hE000; rom[12'h082] = 16'hA00C;
    rom[12'h083] = 16'hC004; rom[12'h084] = 16'h7000;

    // rr=1: SKZ passes, JMP at 3 taken, then 0x80 -> 4 -> 0x40 -> RTN
    do_reset(1'b1);
    e("ld0",     1, 4'h1, 4'h3, 0, 0,      4'b0000, 0, 1);
    e("nop0",    1, 4'h0, 4'h0, 0, 0,      4'b0010, 0, 1);
    e("skz_rr1", 1, 4'hE, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("jmp080",  1, 4'hC, 4'h0, 1, 12'h080, 4'b1000, 0, 1);
    e("sq_004",  0, 4'hF, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("a080",    1, 4'h9, 4'hB, 0, 0,      4'b0000, 0, 1);
    e("skz081",  1, 4'hE, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("a082",    1, 4'hA, 4'hC, 0, 0,      4'b0000, 0, 1);
    e("jmp004",  1, 4'hC, 4'h4, 1, 12'h004, 4'b1000, 0, 1);
    e("sq_084",  0, 4'h7, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("nopf4",   1, 4'hF, 4'h0, 0, 0,      4'b0001, 0, 1);
    e("jmp040",  1, 4'hC, 4'h0, 1, 12'h040, 4'b1000, 0, 1);
    e("sq_006",  0, 4'h2, 4'h6, 0, 0,      4'b0000, 0, 1);
    e("a040",    1, 4'h3, 4'h5, 0, 0,      4'b0000, 0, 1);
    e("a041",    1, 4'h8, 4'hA, 0, 0,      4'b0000, 0, 1);
`ifdef FD_CALL_STACK_EN
    e("rtn_pop", 1, 4'hD, 4'h0, 1, 12'h006, 4'b0100, 0, 1);
    e("sq_043",  0, 4'h5, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("a006",    1, 4'h2, 4'h6, 0, 0,      4'b0000, 0, 1);
`else
    e("rtn_nostk", 1, 4'hD, 4'h0, 0, 0,    4'b0100, 0, 1);
    e("sq_043",  0, 4'h5, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("a044",    1, 4'h6, 4'h9, 0, 0,      4'b0000, 0, 1);
`endif
    drain();

    // rr=0: SKZ squashes JMP at 3, then reset with a squash pending
    do_reset(1'b0);
    e("ld0_b",   1, 4'h1, 4'h3, 0, 0,      4'b0000, 0, 1);
    e("nop0_b",  1, 4'h0, 4'h0, 0, 0,      4'b0010, 0, 1);
    e("skz_rr0", 1, 4'hE, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("jmp_sq",  0, 4'hC, 4'h0, 0, 0,      4'b0000, 0, 1);
    e("nopf_b",  1, 4'hF, 4'h0, 0, 0,      4'b0001, 0, 1);
    e("jmp040b", 1, 4'hC, 4'h0, 1, 12'h040, 4'b1000, 0, 1);
    drain();
    do_reset(1'b0);
    e("ld0_rst", 1, 4'h1, 4'h3, 0, 0,      4'b0000, 0, 1);
    e("nop0_rst", 1, 4'h0, 4'h0, 0, 0,     4'b0010, 0, 1);
    drain();

`ifdef FD_CALL_STACK_EN
    // five nested calls into a depth-4 stack, unwind, then RTN on empty
    for (int i = 0; i < 4096; i++) rom[i] = 16'h2000;
    rom[12'h000] = 16'hC010; rom[12'h010] = 16'hC020; rom[12'h020] = 16'hC030;
    rom[12'h030] = 16'hC040; rom[12'h040] = 16'hC050; rom[12'h050] = 16'hD000;
    rom[12'h031] = 16'hD000; rom[12'h021] = 16'hD000; rom[12'h011] = 16'hD000;
    rom[12'h001] = 16'hD000; rom[12'h003] = 16'h1000;
    do_reset(1'b1);
    e("j000",   1, 4'hC, 4'h0, 1, 12'h010, 4'b1000, 2'b00, 1);
    e("sq001",  0, 4'hD, 4'h0, 0, 0,      4'b0000, 2'b00, 1);
    e("j010",   1, 4'hC, 4'h0, 1, 12'h020, 4'b1000, 2'b00, 1);
    e("sq011",  0, 4'hD, 4'h0, 0, 0,      4'b0000, 2'b00, 1);
    e("j020",   1, 4'hC, 4'h0, 1, 12'h030, 4'b1000, 2'b00, 1);
    e("sq021",  0, 4'hD, 4'h0, 0, 0,      4'b0000, 2'b00, 1);
    e("j030",   1, 4'hC, 4'h0, 1, 12'h040, 4'b1000, 2'b00, 1);
    e("sq031",  0, 4'hD, 4'h0, 0, 0,      4'b0000, 2'b00, 1);
    e("j040_full", 1, 4'hC, 4'h0, 1, 12'h050, 4'b1000, 2'b00, 1);
    e("sq041_ovf", 0, 4'h2, 4'h0, 0, 0,   4'b0000, 2'b10, 1);
    e("r050",   1, 4'hD, 4'h0, 1, 12'h031, 4'b0100, 2'b10, 1);
    e("sq051",  0, 4'h2, 4'h0, 0, 0,      4'b0000, 2'b10, 1);
    e("r031",   1, 4'hD, 4'h0, 1, 12'h021, 4'b0100, 2'b10, 1);
    e("sq032",  0, 4'h2, 4'h0, 0, 0,      4'b0000, 2'b10, 1);
    e("r021",   1, 4'hD, 4'h0, 1, 12'h011, 4'b0100, 2'b10, 1);
    e("sq022",  0, 4'h2, 4'h0, 0, 0,      4'b0000, 2'b10, 1);
    e("r011",   1, 4'hD, 4'h0, 1, 12'h001, 4'b0100, 2'b10, 1);
    e("sq012",  0, 4'h2, 4'h0, 0, 0,      4'b0000, 2'b10, 1);
    e("r001_empty", 1, 4'hD, 4'h0, 0, 0,  4'b0100, 2'b10, 1);
    e("sq002_unf", 0, 4'h2, 4'h0, 0, 0,   4'b0000, 2'b11, 1);
    e("a003",   1, 4'h1, 4'h0, 0, 0,      4'b0000, 2'b11, 1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter SIZE_LOG, default 12, program address width; matches the program counter.
REQ-002 Parameter IO_W, default 4, I/O address width (IO_W <= SIZE_LOG).
REQ-003 Parameter STACK_DEPTH, default 4, return-stack entries (used only with FD_CALL_STACK_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pc_addr  input  SIZE_LOG  current program counter output, also the synchronous ROM address.
REQ-007 rom_data  input  SIZE_LOG+4  ROM word for the previous cycle's pc_addr; [SIZE_LOG+3:SIZE_LOG] opcode, [SIZE_LOG-1:0] operand.
REQ-008 rr  input  1  result register from the logic unit.
REQ-009 pc_write  output  1  load strobe to the program counter; combinational.
REQ-010 pc_target  output  SIZE_LOG  load value to the program counter; combinational.
REQ-011 instr_valid  output  1  opcode/io_addr are a live instruction this cycle.
REQ-012 opcode  output  4  decoded opcode, rom_data[SIZE_LOG+3:SIZE_LOG].
REQ-013 io_addr  output  IO_W  operand[IO_W-1:0].
REQ-014 jmp_flag, rtn_flag, flg0, flgf  output  1 each  one-cycle pulses for live JMP(0xC), RTN(0xD), NOP0(0x0), NOPF(0xF).
REQ-015 stk_ovf, stk_unf  output  1 each  sticky stack overflow/underflow flags.

Function
REQ-016 FSM states RST_LOAD, FILL, RUN; RST_LOAD->FILL->RUN unconditionally, RUN holds until reset.
REQ-017 RST_LOAD: pc_write=1, pc_target=0, instr_valid=0; FILL: pc_write=0, instr_valid=0 (ROM latency bubble).
REQ-018 instr_addr register captures pc_addr every cycle; in RUN it equals the address of rom_data.
REQ-019 RUN: instr_valid = !squash; all flag pulses and pc_write are gated by instr_valid.
REQ-020 Live JMP: pc_write=1, pc_target=operand same cycle; squash set for the next cycle.
REQ-021 Live SKZ(0xE) with rr=0: squash set for next cycle; rr=1: no effect.
REQ-022 squash clears after exactly one cycle; a squashed JMP/RTN/SKZ has no effect and sets no squash.
REQ-023 Live RTN without stack action: rtn_flag=1, squash set, pc_write=0.
REQ-024 Opcodes 0x1-0xB: decode only, pc_write=0, no squash.
REQ-025 opcode and io_addr follow rom_data combinationally regardless of instr_valid.

Reset
REQ-026 rst_n low at a clock edge: state<=RST_LOAD, squash<=0, instr_addr<=0, stack pointer<=0, stk_ovf<=0, stk_unf<=0.
REQ-027 Reset mid-RUN discards any pending squash and stack contents; instruction stream restarts at address 0 after the FILL bubble.
REQ-028 While in RST_LOAD all pulse outputs and instr_valid are 0.

Configuration
REQ-029 Macro FD_CALL_STACK_EN compiles in a STACK_DEPTH-entry return stack.
REQ-030 With macro: live JMP pushes (instr_addr+1) mod 2^SIZE_LOG; push when full is discarded and sets stk_ovf; jump still taken.
REQ-031 With macro: live RTN with non-empty stack pops, pc_write=1, pc_target=popped value, rtn_flag=1, squash set.
REQ-032 With macro: live RTN on empty stack sets stk_unf and behaves per REQ-023.
REQ-033 Without macro: no stack storage, RTN per REQ-023, stk_ovf and stk_unf tied 0.

Verification
REQ-034 Reset release, ROM[0]=LD(0x1) -> pc_write=1,target=0 in RST_LOAD; bubble; instr_valid=1,opcode=1 two cycles after release.
REQ-035 ROM[5]=JMP 0x040 -> pc_write=1,target=0x040 that cycle; instruction from 6 squashed; next live instruction is ROM[0x040].
REQ-036 SKZ with rr=0 at addr 10, STO at 11 -> instr_valid=0 for addr 11; SKZ with rr=1 -> addr 11 live.
REQ-037 JMP at 3 immediately after a taken SKZ -> JMP squashed, pc_write=0, sequential fetch continues at 4.
REQ-038 Macro on: JMP 0x100 at 0x020, RTN at 0x100 -> pc_target=0x021; five nested JMPs with depth 4 -> stk_ovf=1; RTN on empty -> stk_unf=1, skip only.
REQ-039 rst_n low for one cycle during RUN with squash pending -> RST_LOAD next cycle, flags cleared, restart at 0.
